// File: rtl/rx_frame_controller.sv
// RMII receive frame sequencer between the octet receiver and the RX data FIFO.
// It filters on destination MAC, strips it, forwards the rest and queues one descriptor per accepted frame.
module rx_frame_controller #(
  parameter logic [47:0] MAC_ADDR    = 48'h0200_0000_0001,
  parameter int          MIN_LEN     = 60,
  parameter int          MAX_LEN     = 1514,
  parameter int          DESC_DEPTH  = 4,
  parameter int          IDLE_CYCLES = 4
) (
  input  logic        clk_50_mhz,
  input  logic        rst_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_byte_vld,
  input  logic        crs_dv,
  input  logic        rx_er,
  input  logic        promisc,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [7:0]  fifo_din,
  output logic        desc_valid,
  input  logic        desc_ready,
  output logic [15:0] desc_len,
  output logic [15:0] desc_ethertype,
  output logic [3:0]  desc_status,
  output logic [15:0] drop_count,
  output logic        busy
);

  localparam int PTR_W = (DESC_DEPTH > 1) ? $clog2(DESC_DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam int IDL_W = $clog2(IDLE_CYCLES) + 1;

  localparam logic [15:0]      MIN_LEN_C = 16'(MIN_LEN);
  localparam logic [15:0]      MAX_LEN_C = 16'(MAX_LEN);
  localparam logic [IDL_W-1:0] IDLE_LAST = IDL_W'(IDLE_CYCLES - 1);
  localparam logic [OCC_W-1:0] DEPTH_C   = OCC_W'(DESC_DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE   = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_ZERO  = OCC_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO  = PTR_W'(0);
  localparam logic [IDL_W-1:0] IDL_ZERO  = IDL_W'(0);
  localparam logic [IDL_W-1:0] IDL_ONE   = IDL_W'(1);

  typedef enum logic [2:0] {
    S_WAIT_IDLE = 3'd0,
    S_IDLE      = 3'd1,
    S_DST       = 3'd2,
    S_DATA      = 3'd3,
    S_PUSH      = 3'd4,
    S_DISCARD   = 3'd5
  } state_t;

  typedef struct packed {
    logic [15:0] len;
    logic [15:0] etype;
    logic [3:0]  status;
  } desc_t;

  localparam desc_t DESC_NONE = '{len: 16'd0, etype: 16'd0, status: 4'd0};

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

  state_t           state_q, state_d;
  logic [IDL_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [39:0]      da_q, da_d;
  logic [15:0]      etype_q, etype_d;
  logic             er_q, er_d;
  logic             ovf_q, ovf_d;
  logic [15:0]      drop_q, drop_d;
  logic             wr_en_q, wr_en_d;
  logic [7:0]       din_q, din_d;
  logic             busy_q, busy_d;
  desc_t            mem_q [DESC_DEPTH];
  desc_t            mem_d [DESC_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             dvalid_q, dvalid_d;
  desc_t            dhead_q, dhead_d;

  logic             end_s;
  logic [15:0]      cnt_inc_s;
  logic [47:0]      da_shift_s;
  logic             da_match_s;
  logic             push_s;
  logic             pop_s;
  desc_t            push_entry_s;

  // Frame-end detection: the end is the IDLE_CYCLES-th consecutive crs_dv-low cycle, held while low.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (crs_dv) begin
      idle_cnt_d = IDL_ZERO;
    end else if (idle_cnt_q < IDLE_LAST) begin
      idle_cnt_d = idle_cnt_q + IDL_ONE;
    end else begin
      idle_cnt_d = idle_cnt_q;
    end
  end

  assign end_s        = !crs_dv && (idle_cnt_q >= IDLE_LAST);
  assign cnt_inc_s    = sat_inc16(cnt_q);
  assign da_shift_s   = {da_q, rx_byte};
  assign da_match_s   = (da_shift_s == MAC_ADDR) || (da_shift_s == {48{1'b1}}) || promisc;
  assign pop_s        = dvalid_q && desc_ready;
  assign push_entry_s = '{len:    cnt_q,
                          etype:  (cnt_q >= 16'd14) ? etype_q : 16'd0,
                          status: {ovf_q, (cnt_q > MAX_LEN_C), (cnt_q < MIN_LEN_C), er_q}};

  // Frame sequencer next state and FIFO write path.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    da_d    = da_q;
    etype_d = etype_q;
    er_d    = er_q;
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    wr_en_d = 1'b0;
    din_d   = din_q;
    push_s  = 1'b0;
    case (state_q)
      S_WAIT_IDLE: begin
        if (end_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_IDLE;
        end
      end
      S_IDLE: begin
        if (crs_dv) begin
          cnt_d   = 16'd0;
          da_d    = 40'd0;
          etype_d = 16'd0;
          er_d    = 1'b0;
          ovf_d   = 1'b0;
          // No slot free: the frame is counted and skipped; otherwise a slot stays free until PUSH.
          if (occ_q == DEPTH_C) begin
            drop_d  = sat_inc16(drop_q);
            state_d = S_DISCARD;
          end else begin
            state_d = S_DST;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DST: begin
        er_d = er_q | rx_er;
        if (rx_byte_vld) begin
          cnt_d = cnt_inc_s;
          da_d  = da_shift_s[39:0];
        end else begin
          cnt_d = cnt_q;
          da_d  = da_q;
        end
        if (rx_byte_vld && (cnt_q == 16'd5)) begin
          if (da_match_s) begin
            state_d = end_s ? S_PUSH : S_DATA;
          end else begin
            state_d = end_s ? S_IDLE : S_DISCARD;
          end
        end else if (end_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DST;
        end
      end
      S_DATA: begin
        er_d = er_q | rx_er;
        if (rx_byte_vld) begin
          cnt_d = cnt_inc_s;
          if (cnt_q == 16'd12) begin
            etype_d = {rx_byte, etype_q[7:0]};
          end else if (cnt_q == 16'd13) begin
            etype_d = {etype_q[15:8], rx_byte};
          end else begin
            etype_d = etype_q;
          end
          if (cnt_inc_s <= MAX_LEN_C) begin
            if (fifo_full) begin
              ovf_d = 1'b1;
            end else begin
              wr_en_d = 1'b1;
              din_d   = rx_byte;
            end
          end else begin
            ovf_d = ovf_q;
          end
        end else begin
          cnt_d = cnt_q;
        end
        if (end_s) begin
          state_d = S_PUSH;
        end else begin
          state_d = S_DATA;
        end
      end
      S_PUSH: begin
        push_s  = 1'b1;
        state_d = S_IDLE;
      end
      S_DISCARD: begin
        if (end_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DISCARD;
        end
      end
      default: begin
        state_d = S_WAIT_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Descriptor queue; the head is computed from next-state so a push shows on desc_* one cycle later.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = push_entry_s;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   occ_d = occ_q + OCC_ONE;
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;
    endcase
    if (occ_d != OCC_ZERO) begin
      dvalid_d = 1'b1;
      dhead_d  = mem_d[rd_ptr_d];
    end else begin
      dvalid_d = 1'b0;
      dhead_d  = DESC_NONE;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_50_mhz) begin
    if (!rst_n) begin
      state_q    <= S_WAIT_IDLE;
      idle_cnt_q <= IDL_ZERO;
      cnt_q      <= 16'd0;
      da_q       <= 40'd0;
      etype_q    <= 16'd0;
      er_q       <= 1'b0;
      ovf_q      <= 1'b0;
      drop_q     <= 16'd0;
      wr_en_q    <= 1'b0;
      din_q      <= 8'd0;
      busy_q     <= 1'b0;
      wr_ptr_q   <= PTR_ZERO;
      rd_ptr_q   <= PTR_ZERO;
      occ_q      <= OCC_ZERO;
      dvalid_q   <= 1'b0;
      dhead_q    <= DESC_NONE;
      for (int i = 0; i < DESC_DEPTH; i++) begin
        mem_q[i] <= DESC_NONE;
      end
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      cnt_q      <= cnt_d;
      da_q       <= da_d;
      etype_q    <= etype_d;
      er_q       <= er_d;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
      wr_en_q    <= wr_en_d;
      din_q      <= din_d;
      busy_q     <= busy_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      dvalid_q   <= dvalid_d;
      dhead_q    <= dhead_d;
      for (int i = 0; i < DESC_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign fifo_wr_en     = wr_en_q;
  assign fifo_din       = din_q;
  assign desc_valid     = dvalid_q;
  assign desc_len       = dhead_q.len;
  assign desc_ethertype = dhead_q.etype;
  assign desc_status    = dhead_q.status;
  assign drop_count     = drop_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_rx_frame_controller.sv
// Scoreboard bench for rx_frame_controller: expected FIFO bytes and descriptors are queued as
// frames are driven and compared when the DUT writes or presents them.
`timescale 1ns/1ps
module tb_rx_frame_controller;

  localparam logic [47:0] MAC   = 48'h0200_0000_0001;
  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] OTHER = 48'h0200_0000_0002;
  localparam int DEPTH = 4;
  localparam int MAXL  = 1514;
  localparam int MINL  = 60;

  logic        clk_50_mhz = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_byte;
  logic        rx_byte_vld;
  logic        crs_dv;
  logic        rx_er;
  logic        promisc;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_din;
  logic        desc_valid;
  logic        desc_ready;
  logic [15:0] desc_len;
  logic [15:0] desc_ethertype;
  logic [3:0]  desc_status;
  logic [15:0] drop_count;
  logic        busy;

  int total = 0;
  int bad   = 0;
  logic [7:0]  exp_bytes[$];
  logic [35:0] exp_desc[$];
  int exp_drop = 0;

  always #10 clk_50_mhz = ~clk_50_mhz;

  rx_frame_controller dut (
    .clk_50_mhz     (clk_50_mhz),
    .rst_n          (rst_n),
    .rx_byte        (rx_byte),
    .rx_byte_vld    (rx_byte_vld),
    .crs_dv         (crs_dv),
    .rx_er          (rx_er),
    .promisc        (promisc),
    .fifo_full      (fifo_full),
    .fifo_wr_en     (fifo_wr_en),
    .fifo_din       (fifo_din),
    .desc_valid     (desc_valid),
    .desc_ready     (desc_ready),
    .desc_len       (desc_len),
    .desc_ethertype (desc_ethertype),
    .desc_status    (desc_status),
    .drop_count     (drop_count),
    .busy           (busy)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // FIFO write scoreboard
  always @(negedge clk_50_mhz) begin
    if (fifo_wr_en === 1'b1) begin
      check_val("fifo_pending", 64'(exp_bytes.size() > 0), 64'd1);
      if (exp_bytes.size() > 0) check_val("fifo_din", 64'(fifo_din), 64'(exp_bytes.pop_front()));
    end
  end

  // Descriptor scoreboard: compared on each pop handshake
  always @(negedge clk_50_mhz) begin
    if (desc_valid === 1'b1 && desc_ready === 1'b1) begin
      check_val("desc_pending", 64'(exp_desc.size() > 0), 64'd1);
      if (exp_desc.size() > 0)
        check_val("desc", 64'({desc_len, desc_ethertype, desc_status}), 64'(exp_desc.pop_front()));
    end
  end

  function automatic logic [7:0] byte_at(input int i, input int n, input logic [47:0] da,
                                         input logic [15:0] et);
    logic [47:0] d;
    logic [15:0] e;
    d = da;
    e = et;
    if (i < 6) return d[47-8*i -: 8];
    if (i == 12) return e[15:8];
    if (i == 13) return e[7:0];
    return 8'((i * 7 + n) & 255);
  endfunction

  // Drive one frame (octet every other cycle) and model its expected effect.
  task automatic send_frame(input int n, input logic [47:0] da, input logic [15:0] et,
                            input int er_at, input int full_at, input int rst_at,
                            input bit ignored, input int gap);
    logic [7:0] b;
    logic [3:0] st;
    bit acc, ovf, w;
    ovf = 1'b0;
    if (ignored) begin
      acc = 1'b0;
    end else if (exp_desc.size() >= DEPTH) begin
      acc = 1'b0;
      if (exp_drop < 65535) exp_drop++;
    end else begin
      acc = (da == MAC) || (da == BCAST) || (promisc == 1'b1);
    end
    @(posedge clk_50_mhz); #1;
    crs_dv = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) begin
        @(posedge clk_50_mhz); #1;
        rst_n = 1'b0;
        @(posedge clk_50_mhz); #1;
        @(negedge clk_50_mhz);
        check_val("rst_outs", 64'({fifo_wr_en, desc_valid, drop_count, busy}), 64'd0);
        @(posedge clk_50_mhz); #1;
        rst_n = 1'b1;
        acc = 1'b0;
        exp_drop = 0;
        exp_desc.delete();
      end
      b = byte_at(i, n, da, et);
      @(posedge clk_50_mhz); #1;
      rx_byte     = b;
      rx_byte_vld = 1'b1;
      rx_er       = (i == er_at);
      fifo_full   = (i == full_at);
      w = acc && (i >= 6) && (i + 1 <= MAXL) && (i != full_at);
      if (acc && (i >= 6) && (i + 1 <= MAXL) && (i == full_at)) ovf = 1'b1;
      if (w) exp_bytes.push_back(b);
      @(posedge clk_50_mhz); #1;
      rx_byte_vld = 1'b0;
      rx_er       = 1'b0;
      fifo_full   = (i == full_at) || (i + 1 == full_at);
      @(negedge clk_50_mhz);
      check_val("wr_timing", 64'(fifo_wr_en), 64'(w));
    end
    if (acc) begin
      st = {ovf, (n > MAXL), (n < MINL), (er_at >= 0 && er_at < n)};
      exp_desc.push_back({16'(n), (n >= 14) ? et : 16'h0000, st});
    end
    @(posedge clk_50_mhz); #1;
    crs_dv = 1'b0;
    repeat (gap - 1) begin
      @(posedge clk_50_mhz); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; crs_dv = 1'b0; rx_byte_vld = 1'b0; rx_byte = 8'd0; rx_er = 1'b0;
    promisc = 1'b0; fifo_full = 1'b0; desc_ready = 1'b1;
    repeat (3) @(posedge clk_50_mhz);
    @(negedge clk_50_mhz);
    check_val("reset_outs", 64'({fifo_wr_en, fifo_din, desc_valid, desc_len, desc_ethertype,
                                 desc_status, drop_count, busy}), 64'd0);
    @(posedge clk_50_mhz); #1;
    rst_n = 1'b1;
    @(posedge clk_50_mhz);
    @(negedge clk_50_mhz);
    check_val("busy_wait_idle", 64'(busy), 64'd1);
    repeat (5) @(posedge clk_50_mhz);
    @(negedge clk_50_mhz);
    check_val("busy_idle", 64'(busy), 64'd0);

    // Unicast, broadcast, filtered and promiscuous frames
    send_frame(64, MAC, 16'h0800, -1, -1, -1, 1'b0, 8);
    send_frame(64, BCAST, 16'h0806, -1, -1, -1, 1'b0, 8);
    send_frame(64, OTHER, 16'h0800, -1, -1, -1, 1'b0, 8);
    promisc = 1'b1;
    send_frame(64, OTHER, 16'h88CC, -1, -1, -1, 1'b0, 8);
    promisc = 1'b0;

    // Length boundaries, rx_er and FIFO overflow
    send_frame(12, MAC, 16'h1234, -1, -1, -1, 1'b0, 8);
    send_frame(59, MAC, 16'h0800, -1, -1, -1, 1'b0, 8);
    send_frame(60, MAC, 16'h0800, -1, -1, -1, 1'b0, 8);
    send_frame(40, MAC, 16'h86DD, 20, -1, -1, 1'b0, 8);
    send_frame(1520, MAC, 16'h0800, -1, 100, -1, 1'b0, 8);
    send_frame(1514, MAC, 16'h0800, -1, -1, -1, 1'b0, 8);
    check_val("drop_none", 64'(drop_count), 64'(exp_drop));

    // Queue full: fifth frame dropped, head stable while not ready
    desc_ready = 1'b0;
    for (int k = 0; k < 5; k++) send_frame(60 + k, MAC, 16'h0800 + 16'(k), -1, -1, -1, 1'b0, 8);
    check_val("drop_count", 64'(drop_count), 64'(exp_drop));
    check_val("drop_one", 64'(exp_drop), 64'd1);
    check_val("desc_held", 64'(desc_valid), 64'd1);
    check_val("head_a", 64'({desc_len, desc_ethertype, desc_status}), 64'(exp_desc[0]));
    repeat (5) @(posedge clk_50_mhz);
    @(negedge clk_50_mhz);
    check_val("head_b", 64'({desc_len, desc_ethertype, desc_status}), 64'(exp_desc[0]));
    @(posedge clk_50_mhz); #1;
    desc_ready = 1'b1;
    repeat (10) @(posedge clk_50_mhz);
    @(negedge clk_50_mhz);
    check_val("desc_drained", 64'(desc_valid), 64'd0);
    check_val("desc_q_empty", 64'(exp_desc.size()), 64'd0);

    // Reset mid-frame flushes a pending descriptor; restart needs a full idle gap
    @(posedge clk_50_mhz); #1;
    desc_ready = 1'b0;
    send_frame(64, MAC, 16'h0800, -1, -1, -1, 1'b0, 8);
    send_frame(64, MAC, 16'h0800, -1, -1, 30, 1'b0, 2);
    desc_ready = 1'b1;
    send_frame(64, MAC, 16'h0800, -1, -1, -1, 1'b1, 8);
    send_frame(64, MAC, 16'h0900, -1, -1, -1, 1'b0, 8);
    check_val("drop_after_rst", 64'(drop_count), 64'(exp_drop));

    repeat (10) @(posedge clk_50_mhz);
    @(negedge clk_50_mhz);
    check_val("bytes_left", 64'(exp_bytes.size()), 64'd0);
    check_val("desc_left", 64'(exp_desc.size()), 64'd0);
    check_val("final_valid", 64'(desc_valid), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
